// File: rtl/axi_mem_arbiter.sv
// Two-requester native-memory to AXI4-Lite arbiter, one transaction in flight.
// Define AXI_MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module axi_mem_arbiter #(
  parameter logic [2:0] INSTR_ARPROT = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_instr,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic [1:0]  req_ready,
  output logic [31:0] req_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  typedef enum logic [1:0] {
    IDLE, ADDR, RESP, DONE
  } state_e;

  state_e      state_q;
  logic        grant_q;
  logic        instr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        arvalid_q;
  logic        bready_q;
  logic        rready_q;
  logic [1:0]  req_ready_q;
  logic [31:0] rdata_q;
`ifndef AXI_MEM_ARB_FIXED_PRIO_EN
  logic        last_grant_q;
`endif

  logic        pick;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_instr;
  logic        aw_hs;
  logic        w_hs;

  always_comb begin
`ifdef AXI_MEM_ARB_FIXED_PRIO_EN
    pick = ~req_valid[0];
`else
    // On contention, serve whoever was not served last
    pick = (&req_valid) ? ~last_grant_q : ~req_valid[0];
`endif
  end

  assign sel_addr  = pick ? req_addr[63:32]  : req_addr[31:0];
  assign sel_wdata = pick ? req_wdata[63:32] : req_wdata[31:0];
  assign sel_wstrb = pick ? req_wstrb[7:4]   : req_wstrb[3:0];
  assign sel_instr = pick ? req_instr[1]     : req_instr[0];

  assign aw_hs = awvalid_q & mem_axi_awready;
  assign w_hs  = wvalid_q & mem_axi_wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      instr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      req_ready_q  <= '0;
      rdata_q      <= '0;
`ifndef AXI_MEM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      req_ready_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q   <= pick;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            wstrb_q   <= sel_wstrb;
            instr_q   <= sel_instr;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifndef AXI_MEM_ARB_FIXED_PRIO_EN
            last_grant_q <= pick;
`endif
            if (|sel_wstrb) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              arvalid_q <= 1'b1;
            end
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (|wstrb_q) begin
            if (aw_hs) begin
              awvalid_q <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (w_hs) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
              bready_q <= 1'b1;
              state_q  <= RESP;
            end
          end else if (mem_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (rready_q & mem_axi_rvalid) begin
            rready_q              <= 1'b0;
            rdata_q               <= mem_axi_rdata;
            req_ready_q[grant_q]  <= 1'b1;
            state_q               <= DONE;
          end else if (bready_q & mem_axi_bvalid) begin
            bready_q              <= 1'b0;
            req_ready_q[grant_q]  <= 1'b1;
            state_q               <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign req_rdata       = rdata_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = wstrb_q;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = instr_q ? INSTR_ARPROT : 3'b000;
  assign mem_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: directed vector table, contention and
// reset-in-response sequences against a delay-programmable AXI slave.
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_instr;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_ready;
  logic [31:0] req_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;

  axi_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_instr(req_instr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ready(req_ready),
    .req_rdata(req_rdata),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
    .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
    .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
    .mem_axi_rdata(rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave: each ready/valid waits its programmed number of cycles
  int ar_d, aw_d, w_d, r_d, b_d;
  int ar_c, aw_c, w_c, r_c, b_c;
  logic [31:0] s_rdata;

  always @(negedge clk) begin
    if (reset) begin
      arready = 0; awready = 0; wready = 0;
      rvalid = 0; bvalid = 0; rdata = '0;
      ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
    end else begin
      arready = arvalid && ar_c >= ar_d;
      ar_c = (arvalid && !arready) ? ar_c + 1 : 0;
      awready = awvalid && aw_c >= aw_d;
      aw_c = (awvalid && !awready) ? aw_c + 1 : 0;
      wready = wvalid && w_c >= w_d;
      w_c = (wvalid && !wready) ? w_c + 1 : 0;
      rvalid = rready && r_c >= r_d;
      rdata = rvalid ? s_rdata : 32'h0;
      r_c = (rready && !rvalid) ? r_c + 1 : 0;
      bvalid = bready && b_c >= b_d;
      b_c = (bready && !bvalid) ? b_c + 1 : 0;
    end
  end

  typedef struct {
    int          rq;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    int          ard, awd, wd, rd, bd;
    logic [31:0] rdat;
    logic [2:0]  eprot;
    int          edone;
  } vec_t;

  vec_t vecs[7];
  vec_t rec_v;

  task automatic run_vec(input vec_t v);
    int done, first, arc, awc, wc, rc, bc;
    logic wr;
    done = 0; first = -1;
    arc = 0; awc = 0; wc = 0; rc = 0; bc = 0;
    wr = |v.strb;
    ar_d = v.ard; aw_d = v.awd; w_d = v.wd;
    r_d = v.rd; b_d = v.bd; s_rdata = v.rdat;
    // The idle lane carries inverted values to catch lane-select errors
    if (v.rq == 0) begin
      req_valid = 2'b01;
      req_instr = {~v.instr, v.instr};
      req_addr  = {~v.addr, v.addr};
      req_wdata = {~v.wdat, v.wdat};
      req_wstrb = {~v.strb, v.strb};
    end else begin
      req_valid = 2'b10;
      req_instr = {v.instr, ~v.instr};
      req_addr  = {v.addr, ~v.addr};
      req_wdata = {v.wdat, ~v.wdat};
      req_wstrb = {v.strb, ~v.strb};
    end
    for (int k = 1; k <= 40 && done == 0; k++) begin
      @(posedge clk); #1;
      if (arvalid) begin
        arc++;
        if (first < 0) first = k;
        chk("araddr", araddr, v.addr);
        chk("arprot", arprot, v.eprot);
      end
      if (awvalid) begin
        awc++;
        if (first < 0) first = k;
        chk("awaddr", awaddr, v.addr);
        chk("awprot", awprot, 3'b000);
      end
      if (wvalid) begin
        wc++;
        chk("wdata", wdata, v.wdat);
        chk("wstrb", wstrb, v.strb);
      end
      if (rready) rc++;
      if (bready) bc++;
      chk("chan_overlap", (arvalid | awvalid | wvalid) & (rready | bready),
          0);
      if (req_ready != 2'b00) begin
        done = k;
        chk("req_ready_sel", req_ready, 2'b01 << v.rq);
        if (!wr) chk("req_rdata", req_rdata, v.rdat);
        req_valid = 2'b00;
      end
    end
    chk("done_cycle", done, v.edone);
    chk("first_valid_cycle", first, 1);
    if (wr) begin
      chk("awvalid_cycles", awc, v.awd + 1);
      chk("wvalid_cycles", wc, v.wd + 1);
      chk("bready_cycles", bc, v.bd + 1);
      chk("no_ar_on_write", arc, 0);
    end else begin
      chk("arvalid_cycles", arc, v.ard + 1);
      chk("rready_cycles", rc, v.rd + 1);
      chk("no_aw_on_read", awc + wc, 0);
    end
    @(posedge clk); #1;
    chk("req_ready_width", req_ready, 2'b00);
  endtask

  initial begin
    int g;
    vecs[0] = '{0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                32'hDEADBEEF, 3'b000, 3};
    vecs[1] = '{1, 1'b0, 32'h200, 32'h12345678, 4'b0011, 0, 0, 2, 0, 0,
                32'h0, 3'b000, 5};
    vecs[2] = '{1, 1'b1, 32'h300, 32'h0, 4'h0, 0, 0, 0, 0, 0,
                32'hCAFEF00D, 3'b100, 3};
    vecs[3] = '{0, 1'b0, 32'h400, 32'h0, 4'h0, 10, 0, 0, 0, 0,
                32'h0BADF00D, 3'b000, 13};
    vecs[4] = '{0, 1'b0, 32'h500, 32'hA5A5A5A5, 4'b1111, 0, 3, 1, 0, 2,
                32'h0, 3'b000, 8};
    vecs[5] = '{1, 1'b0, 32'h604, 32'h0, 4'h0, 0, 0, 0, 4, 0,
                32'h13579BDF, 3'b000, 7};
    vecs[6] = '{0, 1'b0, 32'h708, 32'hFEEDFACE, 4'b1000, 0, 2, 0, 0, 0,
                32'h0, 3'b000, 5};
    rec_v   = '{1, 1'b0, 32'h800, 32'h0, 4'h0, 1, 0, 0, 1, 0,
                32'h2468ACE0, 3'b000, 5};

    reset = 1'b1;
    req_valid = '0; req_instr = '0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0;
    ar_d = 0; aw_d = 0; w_d = 0; r_d = 0; b_d = 0; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_req_rdata", req_rdata, 0);
    chk("rst_addr", {awaddr, araddr}, 0);
    chk("rst_data", {wdata, wstrb, awprot, arprot}, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Both requesters hold reads continuously from a fresh reset
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ar_d = 0; r_d = 0; s_rdata = 32'h55AA55AA;
    req_valid = 2'b11; req_instr = 2'b00; req_wstrb = 8'h00;
    req_addr = {32'h2000, 32'h1000};
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
`ifdef AXI_MEM_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = ((k - 1) / 4) % 2;
`endif
      if (k % 4 == 1)
        chk("contend_araddr", araddr, (g == 1) ? 32'h2000 : 32'h1000);
      if (k % 4 == 3)
        chk("contend_grant", req_ready, 2'b01 << g);
      else
        chk("contend_idle", req_ready, 2'b00);
    end
    req_valid = 2'b00;

    // Reset while waiting for the read response
    ar_d = 0; r_d = 5; s_rdata = 32'h11112222;
    req_valid = 2'b01; req_addr = {32'h0, 32'h900};
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("resp_rready", rready, 1'b1);
    reset = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    chk("midrst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("midrst_req", {req_ready, req_rdata}, 0);
    chk("midrst_addr", araddr, 0);
    reset = 1'b0;
    run_vec(rec_v);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
